// File: rtl/mdu_pkg.sv
// Shared op codes, HI/LO read selects and default latencies for the multiply/divide unit.
// Optional build macro MIPS_MDU_MADD_EN enables the multiply-accumulate ops (codes 7-10).
package mdu_pkg;

    localparam logic [3:0] MDU_NOP   = 4'd0;
    localparam logic [3:0] MDU_MULT  = 4'd1;
    localparam logic [3:0] MDU_MULTU = 4'd2;
    localparam logic [3:0] MDU_DIV   = 4'd3;
    localparam logic [3:0] MDU_DIVU  = 4'd4;
    localparam logic [3:0] MDU_MTHI  = 4'd5;
    localparam logic [3:0] MDU_MTLO  = 4'd6;
    localparam logic [3:0] MDU_MADD  = 4'd7;
    localparam logic [3:0] MDU_MADDU = 4'd8;
    localparam logic [3:0] MDU_MSUB  = 4'd9;
    localparam logic [3:0] MDU_MSUBU = 4'd10;

    localparam logic [1:0] HILO_NONE = 2'd0;
    localparam logic [1:0] HILO_HI   = 2'd1;
    localparam logic [1:0] HILO_LO   = 2'd2;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    // Ops that occupy the unit for a latency window; MADD family only when built in.
    function automatic logic is_multi(input logic [3:0] op);
        logic r;
        case (op)
            MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: r = 1'b1;
`ifdef MIPS_MDU_MADD_EN
            MDU_MADD, MDU_MADDU, MDU_MSUB, MDU_MSUBU: r = 1'b1;
`endif
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic is_div(input logic [3:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational datapath: 64-bit products, truncating divide and (with MIPS_MDU_MADD_EN)
// accumulate onto the current HI/LO pair. Result is latched by the top only on accept.
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic [31:0] hi_val,
    input  logic [31:0] lo_val,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo,
    output logic        div_zero
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        div_signed;
    logic        neg_a;
    logic        neg_b;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] divisor;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quot;
    logic [31:0] rem;

    assign prod_u = {32'd0, rs_val} * {32'd0, rt_val};
    assign prod_s = $signed({{32{rs_val[31]}}, rs_val}) * $signed({{32{rt_val[31]}}, rt_val});

    // Divide on magnitudes so 0x80000000 / -1 falls out naturally as 0x80000000 rem 0.
    assign div_signed = (op == MDU_DIV);
    assign neg_a      = div_signed & rs_val[31];
    assign neg_b      = div_signed & rt_val[31];
    assign mag_a      = neg_a ? -rs_val : rs_val;
    assign mag_b      = neg_b ? -rt_val : rt_val;
    assign divisor    = (rt_val == 32'd0) ? 32'd1 : mag_b;
    assign q_mag      = mag_a / divisor;
    assign r_mag      = mag_a % divisor;
    assign quot       = (neg_a ^ neg_b) ? -q_mag : q_mag;
    assign rem        = neg_a ? -r_mag : r_mag;

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        {res_hi, res_lo} = 64'd0;
        div_zero         = 1'b0;
        case (op)
            MDU_MULT:  {res_hi, res_lo} = prod_s;
            MDU_MULTU: {res_hi, res_lo} = prod_u;
            MDU_DIV, MDU_DIVU: begin
                res_hi   = rem;
                res_lo   = quot;
                div_zero = (rt_val == 32'd0);
            end
`ifdef MIPS_MDU_MADD_EN
            MDU_MADD:  {res_hi, res_lo} = {hi_val, lo_val} + prod_s;
            MDU_MADDU: {res_hi, res_lo} = {hi_val, lo_val} + prod_u;
            MDU_MSUB:  {res_hi, res_lo} = {hi_val, lo_val} - prod_s;
            MDU_MSUBU: {res_hi, res_lo} = {hi_val, lo_val} - prod_u;
`else
            default: begin
                // HI/LO only feed the accumulate ops; keep them visibly consumed.
                res_hi = hi_val & 32'd0;
                res_lo = lo_val & 32'd0;
            end
`endif
        endcase
    end

endmodule

// File: rtl/mips_mdu.sv
// E-stage multiply/divide unit: owns HI/LO, holds results in pend_* until the latency
// counter expires. Build with MIPS_MDU_MADD_EN to enable MADD/MADDU/MSUB/MSUBU.
module mips_mdu
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  mdu_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic [1:0]  read_hilo,
    output logic        busy,
    output logic [31:0] hilo_rdata
);

    localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic [31:0]      pend_hi_q, pend_hi_d;
    logic [31:0]      pend_lo_q, pend_lo_d;

    logic [31:0] res_hi;
    logic [31:0] res_lo;
    logic        div_zero;
    logic        accept;

    mdu_arith u_arith (
        .op       (mdu_op),
        .rs_val   (rs_val),
        .rt_val   (rt_val),
        .hi_val   (hi_q),
        .lo_val   (lo_q),
        .res_hi   (res_hi),
        .res_lo   (res_lo),
        .div_zero (div_zero)
    );

    assign busy   = (cnt_q != '0);
    assign accept = start && !busy && is_multi(mdu_op);

    always_comb begin
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;

        if (accept) begin
            cnt_d = is_div(mdu_op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            // A zero divisor commits the untouched HI/LO, which cannot change while busy.
            if (div_zero) begin
                pend_hi_d = hi_q;
                pend_lo_d = lo_q;
            end else begin
                pend_hi_d = res_hi;
                pend_lo_d = res_lo;
            end
        end else if (busy) begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) begin
                hi_d = pend_hi_q;
                lo_d = pend_lo_q;
            end
        end else if (mdu_op == MDU_MTHI) begin
            hi_d = rs_val;
        end else if (mdu_op == MDU_MTLO) begin
            lo_d = rs_val;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; the synchronous reset
    // clears every register, including pend_*, so no stale result can commit later.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
        end else begin
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
        end
    end

    always_comb begin
        case (read_hilo)
            HILO_HI: hilo_rdata = hi_q;
            HILO_LO: hilo_rdata = lo_q;
            default: hilo_rdata = 32'd0;
        endcase
    end

endmodule
